// File: rtl/step_ex_cpt.sv
// step_ex_cpt: CPT execute step, copies r0 into the register selected by reg_id; pc writes enabled by STEP_EX_CPT_PC_WRITE_EN
module step_ex_cpt #(
  parameter int WE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       ena_,
  output logic       rdy_,
  input  logic [3:0] reg_id,
  input  logic [7:0] r0_dout,
  output logic [7:0] r0_din,
  output logic [7:0] r1_din,
  output logic [7:0] r2_din,
  output logic [7:0] r3_din,
  output logic [7:0] r4_din,
  output logic [7:0] r5_din,
  output logic [7:0] fl_din,
  output logic [7:0] pc_din,
  output logic       r0_we_,
  output logic       r1_we_,
  output logic       r2_we_,
  output logic       r3_we_,
  output logic       r4_we_,
  output logic       r5_we_,
  output logic       fl_we_,
  output logic       pc_we_
);
  typedef enum logic [1:0] {IDLE, LATCH, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [7:0] data;
  logic [3:0] id;
  logic ok, drive, strobe;
  // state, counter and the operand latches; a strobe always recaptures r0 and reg_id
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
      cnt <= '0;
      data <= '0;
      id <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (!ena_) begin
        data <= r0_dout;
        id <= reg_id;
      end
    end
  end
  // next state: ena_ wins from any state, otherwise LATCH -> WRITE (counted) -> DONE -> IDLE
  always_comb begin
    state_nx = !ena_ ? LATCH : state == LATCH ? WRITE : state == WRITE ? (cnt == 4'd0 ? DONE : WRITE) : IDLE;
    cnt_nx = state == LATCH ? 4'(WE_CYCLES - 1) : (state == WRITE && cnt != 4'd0) ? cnt - 4'd1 : cnt;
  end
  // which latched ids map to a writable bus; data is held through DONE for hold time
  always_comb begin
`ifdef STEP_EX_CPT_PC_WRITE_EN
    ok = id <= 4'd5 || id == 4'd10 || id == 4'd15;
`else
    ok = id <= 4'd5 || id == 4'd10;
`endif
    drive = ok && (state == WRITE || state == DONE);
    strobe = ok && state == WRITE;
  end
  assign rdy_   = state == DONE ? 1'b0 : 1'bz;
  assign r0_din = drive && id == 4'd0  ? data : 8'bz;
  assign r1_din = drive && id == 4'd1  ? data : 8'bz;
  assign r2_din = drive && id == 4'd2  ? data : 8'bz;
  assign r3_din = drive && id == 4'd3  ? data : 8'bz;
  assign r4_din = drive && id == 4'd4  ? data : 8'bz;
  assign r5_din = drive && id == 4'd5  ? data : 8'bz;
  assign fl_din = drive && id == 4'd10 ? data : 8'bz;
  assign r0_we_ = strobe && id == 4'd0  ? 1'b0 : 1'bz;
  assign r1_we_ = strobe && id == 4'd1  ? 1'b0 : 1'bz;
  assign r2_we_ = strobe && id == 4'd2  ? 1'b0 : 1'bz;
  assign r3_we_ = strobe && id == 4'd3  ? 1'b0 : 1'bz;
  assign r4_we_ = strobe && id == 4'd4  ? 1'b0 : 1'bz;
  assign r5_we_ = strobe && id == 4'd5  ? 1'b0 : 1'bz;
  assign fl_we_ = strobe && id == 4'd10 ? 1'b0 : 1'bz;
`ifdef STEP_EX_CPT_PC_WRITE_EN
  assign pc_din = drive && id == 4'd15 ? data : 8'bz;
  assign pc_we_ = strobe && id == 4'd15 ? 1'b0 : 1'bz;
`else
  assign pc_din = 8'bz;
  assign pc_we_ = 1'bz;
`endif
endmodule
